uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: echo FIFO entries, power of two.
REQ-002 Parameter ECHO_BURST, default 8: maximum echo bytes per echo grant.
REQ-003 sys_clk  in  1  single clock for the block; all logic on its rising edge.
REQ-004 sys_rst  in  1  reset, synchronous, active-high.
REQ-005 rpt_data  in  8  report-frame byte from the periodic ADC report source.
REQ-006 rpt_valid  in  1  rpt_data valid; held until accepted.
REQ-007 rpt_last  in  1  marks the final byte of a report frame; qualified by rpt_valid.
REQ-008 rpt_ready  out  1  arbiter accepts rpt_data this cycle.
REQ-009 echo_data  in  8  byte from the UART receiver.
REQ-010 echo_valid  in  1  one-cycle strobe; no backpressure.
REQ-011 tx_data  out  8  byte to the UART transmitter.
REQ-012 tx_data_valid  out  1  tx_data valid; held with stable tx_data until accepted.
REQ-013 tx_data_ready  in  1  transmitter ready; transfer occurs on tx_data_valid && tx_data_ready.
REQ-014 busy  out  1  high whenever state is not IDLE or tx_data_valid is high.
REQ-015 echo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-016 echo_drop  out  1  one-cycle pulse when an echo byte is discarded.
REQ-017 drop_cnt  out  8  saturating count of discarded echo bytes.

Function
REQ-018 States SHALL be IDLE, RPT and ECHO; encoding lives in the shared package.
REQ-019 The output stage SHALL be one register; it is free when !tx_data_valid || tx_data_ready.
REQ-020 IDLE, only rpt_valid: next state RPT. IDLE, only FIFO non-empty: next state ECHO. IDLE, both requesting: grant the requester not granted last (last_grant flag; reset value favours RPT).
REQ-021 RPT: rpt_ready = output stage free; each accepted byte loads tx_data with tx_data_valid=1 on the next edge.
REQ-022 RPT: echo bytes SHALL NOT be interleaved; accepting a byte with rpt_last=1 returns the FSM to IDLE and sets last_grant=RPT.
REQ-023 ECHO: when the output stage is free and the FIFO is non-empty, pop one byte into the output register; rpt_ready=0.
REQ-024 ECHO exit to IDLE: ECHO_BURST bytes popped in this grant, or the FIFO goes empty after a pop; sets last_grant=ECHO.
REQ-025 The output register clears tx_data_valid on transfer when no new byte loads in the same cycle; back-to-back loads give one byte per cycle while tx_data_ready=1.
REQ-026 Echo write SHALL be accepted when not full, or when full and a pop occurs in the same cycle.
REQ-027 Otherwise an echo_valid write SHALL be discarded: echo_drop=1 for that cycle, drop_cnt+1, saturating at 255.
REQ-028 A byte written at edge N SHALL be poppable from edge N+1; a write to an empty FIFO while in IDLE gives tx_data_valid=1 at edge N+2.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; echo_level equals writes minus pops and SHALL never exceed FIFO_DEPTH.
REQ-030 A report frame in progress SHALL complete even if the FIFO fills; echo overflow is the defined consequence.

Reset
REQ-031 When sys_rst=1, state=IDLE, last_grant=ECHO, FIFO emptied, tx_data=0, tx_data_valid=0, rpt_ready=0, echo_drop=0, drop_cnt=0, echo_level=0, busy=0.
REQ-032 Reset mid-frame or mid-burst SHALL abandon the byte in flight; no partial-frame resume.

Structure
REQ-033 Package uart_arb_pkg SHALL hold the state enum, the grant enum and the DROP_CNT_MAX constant.
REQ-034 The echo FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports for write, read, full, empty and level).

Verification
REQ-035 16-byte frame, rpt_last on byte 16, tx_data_ready always 1 -> 16 bytes emitted in order, one per cycle, then IDLE.
REQ-036 echo 0x55 in IDLE at edge N -> tx_data=0x55 with tx_data_valid=1 at edge N+2; held while tx_data_ready=0.
REQ-037 rpt_valid and 3 FIFO bytes pending in IDLE after reset -> full report frame first, then 3 echo bytes.
REQ-038 12 echo bytes queued, no report, ECHO_BURST=8 -> 8 bytes, IDLE, then the remaining 4 bytes.
REQ-039 tx_data_ready=0, 18 echo strobes -> echo_level=16, 2 echo_drop pulses, drop_cnt=2; a write with a pop while full is accepted with no drop.
REQ-040 sys_rst=1 asserted mid-frame -> outputs at reset values next edge; a fresh frame afterwards transmits correctly.

Source files
------------

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared types and constants for the UART transmit arbiter:
//                arbiter state encoding, grant history encoding and the
//                saturation limit of the echo drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RPT  = 2'd1,
    ST_ECHO = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_RPT  = 1'b0,
    GRANT_ECHO = 1'b1
  } grant_e;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. rd_data always
//                shows the head entry; rd_en pops it. Writes while full are
//                ignored unless a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             w_wr, w_rd;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Qualify requests so the pointers can never over- or under-run.
  assign w_rd = rd_en && !empty;
  assign w_wr = wr_en && (!full || w_rd);

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = w_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (w_wr && !w_rd) begin
      level_d = level_q + 1'b1;
    end else if (!w_wr && w_rd) begin
      level_d = level_q - 1'b1;
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter between whole report frames and
//                bursts of echoed receive bytes. Echo bytes are buffered in a
//                FIFO; overflow drops are flagged and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ECHO_BURST = 8
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [7:0]                    rpt_data,
  input  logic                          rpt_valid,
  input  logic                          rpt_last,
  output logic                          rpt_ready,
  input  logic [7:0]                    echo_data,
  input  logic                          echo_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_data_valid,
  input  logic                          tx_data_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   echo_level,
  output logic                          echo_drop,
  output logic [7:0]                    drop_cnt
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(ECHO_BURST + 1);

  arb_state_e     state_q, state_d;
  grant_e         last_grant_q, last_grant_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;

  logic [7:0]     w_fifo_rd_data;
  logic           w_fifo_full, w_fifo_empty;
  logic [LW-1:0]  w_fifo_level;
  logic           w_out_free, w_rpt_accept, w_pop, w_wr_accept, w_drop;
  logic           w_burst_done, w_fifo_drains;

  assign w_out_free    = !tx_valid_q || tx_data_ready;
  assign w_rpt_accept  = (state_q == ST_RPT) && rpt_valid && w_out_free;
  assign w_pop         = (state_q == ST_ECHO) && w_out_free && !w_fifo_empty;
  assign w_wr_accept   = echo_valid && (!w_fifo_full || w_pop);
  assign w_drop        = echo_valid && !w_wr_accept;
  assign w_burst_done  = (burst_q == BW'(ECHO_BURST - 1));
  assign w_fifo_drains = (w_fifo_level == LW'(1)) && !w_wr_accept;

  assign rpt_ready     = (state_q == ST_RPT) && w_out_free && !sys_rst;
  assign echo_drop     = w_drop && !sys_rst;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign busy          = (state_q != ST_IDLE) || tx_valid_q;
  assign echo_level    = w_fifo_level;
  assign drop_cnt      = drop_cnt_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_echo_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .wr_en   (w_wr_accept && !sys_rst),
    .wr_data (echo_data),
    .rd_en   (w_pop),
    .rd_data (w_fifo_rd_data),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .level   (w_fifo_level)
  );

  // Grant FSM: whole frames for reports, bounded bursts for echo traffic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_d      = burst_q;
    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        if (rpt_valid && !w_fifo_empty) begin
          state_d = (last_grant_q == GRANT_ECHO) ? ST_RPT : ST_ECHO;
        end else if (rpt_valid) begin
          state_d = ST_RPT;
        end else if (!w_fifo_empty) begin
          state_d = ST_ECHO;
        end
      end
      ST_RPT: begin
        if (w_rpt_accept && rpt_last) begin
          state_d      = ST_IDLE;
          last_grant_d = GRANT_RPT;
        end
      end
      ST_ECHO: begin
        if (w_pop) begin
          burst_d = burst_q + 1'b1;
          if (w_burst_done || w_fifo_drains) begin
            state_d      = ST_IDLE;
            last_grant_d = GRANT_ECHO;
          end
        end else if (w_fifo_empty) begin
          state_d      = ST_IDLE;
          last_grant_d = GRANT_ECHO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single output register: load a granted byte, else clear on transfer.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (w_rpt_accept) begin
      tx_data_d  = rpt_data;
      tx_valid_d = 1'b1;
    end else if (w_pop) begin
      tx_data_d  = w_fifo_rd_data;
      tx_valid_d = 1'b1;
    end else if (tx_data_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  // Saturating count of discarded echo bytes.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (w_drop && (drop_cnt_q != DROP_CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_ECHO;
      burst_q      <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_q      <= burst_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter: a cycle
//                table for echo latency and a short frame, then sequences
//                for long frames, arbitration order, burst limits, overflow
//                and reset mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] rpt_data;
  logic       rpt_valid, rpt_last, rpt_ready;
  logic [7:0] echo_data;
  logic       echo_valid;
  logic [7:0] tx_data;
  logic       tx_data_valid, tx_data_ready, busy, echo_drop;
  logic [4:0] echo_level;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(.FIFO_DEPTH(16), .ECHO_BURST(8)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .rpt_data      (rpt_data),
    .rpt_valid     (rpt_valid),
    .rpt_last      (rpt_last),
    .rpt_ready     (rpt_ready),
    .echo_data     (echo_data),
    .echo_valid    (echo_valid),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .busy          (busy),
    .echo_level    (echo_level),
    .echo_drop     (echo_drop),
    .drop_cnt      (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Transmitter model: a transfer happens at the next rising edge.
  always @(negedge sys_clk) begin
    if (!sys_rst && tx_data_valid && tx_data_ready) begin
      got_q.push_back(tx_data);
      got_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic       ev;
    logic [7:0] ed;
    logic       rv;
    logic [7:0] rd;
    logic       rl;
    logic       tr;
    logic       e_rr;
    logic       e_drop;
    logic       e_tv;
    logic [7:0] e_td;
    logic       e_busy;
    logic [4:0] e_lvl;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    rpt_valid = 1'b0; rpt_last = 1'b0; rpt_data = 8'h00;
    echo_valid = 1'b0; echo_data = 8'h00;
    step();
    step();
    sys_rst = 1'b0;
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic send_frame(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      int t;
      rpt_data  = base + 8'(k);
      rpt_last  = (k == n - 1);
      rpt_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge sys_clk);
        if (rpt_ready) break;
        t++;
        if (t > 300) break;
      end
      if (t > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_timeout: byte %0d never accepted", k);
        rpt_valid = 1'b0;
        return;
      end
      step();
    end
    rpt_valid = 1'b0;
    rpt_last  = 1'b0;
  endtask

  task automatic echo_write(input logic [7:0] d);
    echo_valid = 1'b1;
    echo_data  = d;
    step();
    echo_valid = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int t = 0;
    while (got_q.size() < n && t < 300) begin
      step();
      t++;
    end
    check("tx_count", got_q.size(), n);
  endtask

  task automatic compare_q(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check(name, got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int drops;
    tx_data_ready = 1'b0;
    // ev ed rv rd rl tr | rr drop | tv td busy lvl
    vecs[0] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 5'd0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 5'd0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 5'd0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 5'd0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 5'd0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 5'd0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA2, 1'b0, 5'd0};

    // Reset values
    do_reset();
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_valid", tx_data_valid, 1'b0);
    check("rst_rpt_ready", rpt_ready, 1'b0);
    check("rst_echo_drop", echo_drop, 1'b0);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    check("rst_level", echo_level, 5'd0);
    check("rst_busy", busy, 1'b0);

    // Cycle table: echo 0x55 latency and hold, then a two-byte frame
    for (int i = 0; i < 9; i++) begin
      echo_valid = vecs[i].ev;  echo_data = vecs[i].ed;
      rpt_valid  = vecs[i].rv;  rpt_data  = vecs[i].rd;
      rpt_last   = vecs[i].rl;  tx_data_ready = vecs[i].tr;
      #1;
      check($sformatf("vec%0d_rpt_ready", i), rpt_ready, vecs[i].e_rr);
      check($sformatf("vec%0d_echo_drop", i), echo_drop, vecs[i].e_drop);
      step();
      check($sformatf("vec%0d_tx_valid", i), tx_data_valid, vecs[i].e_tv);
      check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].e_td);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_level", i), echo_level, vecs[i].e_lvl);
    end
    echo_valid = 1'b0; rpt_valid = 1'b0; rpt_last = 1'b0;

    // 16-byte frame, one byte per cycle, then idle
    do_reset();
    tx_data_ready = 1'b1;
    send_frame(16, 8'h30);
    wait_q(16);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h30 + 8'(i));
    compare_q("frame16_data");
    if (got_cyc.size() == 16) check("frame16_span", got_cyc[15] - got_cyc[0], 15);
    step();
    check("frame16_idle_busy", busy, 1'b0);

    // Report and echo pending together: frame first, then echo wins the tie
    do_reset();
    tx_data_ready = 1'b1;
    fork
      begin
        send_frame(4, 8'h10);
        send_frame(2, 8'h20);
      end
      begin
        for (int i = 0; i < 3; i++) echo_write(8'hE0 + 8'(i));
      end
    join
    wait_q(9);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hE0, 8'hE1, 8'hE2, 8'h20, 8'h21};
    compare_q("arb_order");

    // 12 queued echo bytes: burst of 8, gap through IDLE, then 4
    do_reset();
    tx_data_ready = 1'b0;
    for (int i = 0; i < 12; i++) echo_write(8'h80 + 8'(i));
    tx_data_ready = 1'b1;
    wait_q(12);
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(8'h80 + 8'(i));
    compare_q("burst_data");
    if (got_cyc.size() == 12) begin
      check("burst_first8_span", got_cyc[7] - got_cyc[0], 7);
      check("burst_gap", got_cyc[8] - got_cyc[7], 2);
      check("burst_last4_span", got_cyc[11] - got_cyc[8], 3);
    end

    // Overflow with a stalled transmitter
    do_reset();
    tx_data_ready = 1'b0;
    send_frame(1, 8'hC3);
    drops = 0;
    for (int i = 0; i < 18; i++) begin
      echo_valid = 1'b1;
      echo_data  = 8'hD0 + 8'(i);
      #1;
      if (echo_drop) drops++;
      step();
    end
    echo_valid = 1'b0;
    check("ovf_level", echo_level, 5'd16);
    check("ovf_drop_pulses", drops, 2);
    check("ovf_drop_cnt", drop_cnt, 8'd2);
    check("ovf_tx_held", tx_data, 8'hC3);
    echo_valid = 1'b1; echo_data = 8'hEE; tx_data_ready = 1'b1;
    #1;
    check("full_pop_no_drop", echo_drop, 1'b0);
    step();
    echo_valid = 1'b0; tx_data_ready = 1'b0;
    check("full_pop_level", echo_level, 5'd16);
    check("full_pop_drop_cnt", drop_cnt, 8'd2);
    check("full_pop_tx_data", tx_data, 8'hD0);
    echo_valid = 1'b1;
    repeat (260) step();
    echo_valid = 1'b0;
    check("drop_cnt_saturate", drop_cnt, 8'd255);

    // Reset mid-frame, then a fresh frame
    do_reset();
    tx_data_ready = 1'b1;
    rpt_valid = 1'b1; rpt_last = 1'b0; rpt_data = 8'h40;
    step();
    step();
    rpt_data = 8'h41;
    step();
    rpt_data = 8'h42;
    step();
    check("midframe_valid_before", tx_data_valid, 1'b1);
    sys_rst = 1'b1; rpt_valid = 1'b0;
    step();
    check("midrst_tx_valid", tx_data_valid, 1'b0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rpt_ready", rpt_ready, 1'b0);
    check("midrst_level", echo_level, 5'd0);
    sys_rst = 1'b0;
    got_q.delete();
    got_cyc.delete();
    send_frame(3, 8'h60);
    wait_q(3);
    exp_q = '{8'h60, 8'h61, 8'h62};
    compare_q("post_rst_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
